// File: rtl/reg_sweep_pkg.sv
// Shared types and constants for the sweep-tracking register file.
package reg_sweep_pkg;

  typedef enum logic [1:0] {IDLE, ACTIVE, COMPLETE} state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int         NREGS    = 32;

  // Sweep length counter: add one, hold at 15.
  function automatic logic [3:0] len_inc(input logic [3:0] len, input logic en);
    return (en && len != 4'hF) ? len + 4'd1 : len;
  endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// 32-entry storage, one write port, two combinational read ports; entry 0 reads as zero.
module regfile_2r1w
  import reg_sweep_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [4:0]       raddr_a_i,
  input  logic [4:0]       raddr_b_i,
  output logic [WIDTH-1:0] rdata_a_o,
  output logic [WIDTH-1:0] rdata_b_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i && waddr_i != REG_ZERO) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // No write bypass: a same-cycle read sees the pre-edge contents.
  assign rdata_a_o = (raddr_a_i == REG_ZERO) ? '0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == REG_ZERO) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/reg_sweep_file.sv
// Register file fed by the regnum sequencer: tracks touched registers, write counts and sweeps.
module reg_sweep_file
  import reg_sweep_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int EXP_LEN = 5,
  parameter int CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       regnum,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             done,
  input  logic             clear_mask,
  input  logic [4:0]       rs_addr,
  input  logic [4:0]       rt_addr,
  output logic [WIDTH-1:0] rs_data,
  output logic [WIDTH-1:0] rt_data,
  output logic [31:0]      written_mask,
  output logic [CNT_W-1:0] write_count,
  output logic             sweep_done,
  output logic [3:0]       sweep_len,
  output logic             sweep_ok
);

  state_e           state_q, state_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       sweep_len_q, sweep_len_d;
  logic             sweep_ok_q, sweep_ok_d;
  logic             sweep_done_q, sweep_done_d;
  logic             done_q;
  logic [31:0]      mask_q, mask_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             acc, rise;

  assign acc  = wr_en && (regnum != REG_ZERO);
  assign rise = done && !done_q;

  regfile_2r1w #(.WIDTH(WIDTH)) u_rf (
    .clock     (clock),
    .reset     (reset),
    .we_i      (acc),
    .waddr_i   (regnum),
    .wdata_i   (wr_data),
    .raddr_a_i (rs_addr),
    .raddr_b_i (rt_addr),
    .rdata_a_o (rs_data),
    .rdata_b_o (rt_data)
  );

  always_comb begin
    mask_d = clear_mask ? '0 : mask_q;
    if (acc) mask_d[regnum] = 1'b1;
    count_d = (acc && count_q != '1) ? count_q + 1'b1 : count_q;
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sweep_len_d  = sweep_len_q;
    sweep_ok_d   = sweep_ok_q;
    sweep_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          state_d = ACTIVE;
          len_d   = 4'd1;
        end
      end
      ACTIVE: begin
        len_d = len_inc(len_q, acc);
        if (rise) begin
          // A write landing on the completing edge still belongs to this sweep.
          state_d      = COMPLETE;
          sweep_len_d  = len_inc(len_q, acc);
          sweep_ok_d   = (len_inc(len_q, acc) == 4'(EXP_LEN));
          sweep_done_d = 1'b1;
        end
      end
      COMPLETE: begin
        state_d = acc ? ACTIVE : IDLE;
        len_d   = acc ? 4'd1 : 4'd0;
      end
      default: begin
        state_d = IDLE;
        len_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      len_q        <= '0;
      sweep_len_q  <= '0;
      sweep_ok_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      done_q       <= 1'b0;
      mask_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sweep_len_q  <= sweep_len_d;
      sweep_ok_q   <= sweep_ok_d;
      sweep_done_q <= sweep_done_d;
      done_q       <= done;
      mask_q       <= mask_d;
      count_q      <= count_d;
    end
  end

  assign written_mask = mask_q;
  assign write_count  = count_q;
  assign sweep_done   = sweep_done_q;
  assign sweep_len    = sweep_len_q;
  assign sweep_ok     = sweep_ok_q;

endmodule

// File: tb/tb_reg_sweep_file.sv
// Directed bench for reg_sweep_file with hand-computed expectations.
module tb_reg_sweep_file;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  regnum;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        done;
  logic        clear_mask;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] written_mask;
  logic [7:0]  write_count;
  logic        sweep_done;
  logic [3:0]  sweep_len;
  logic        sweep_ok;

  int ncmp = 0;
  int nerr = 0;
  int pulses;

  always #5 clock = ~clock;

  reg_sweep_file dut (
    .clock(clock), .reset(reset), .regnum(regnum), .wr_en(wr_en), .wr_data(wr_data),
    .done(done), .clear_mask(clear_mask), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(rs_data), .rt_data(rt_data), .written_mask(written_mask),
    .write_count(write_count), .sweep_done(sweep_done), .sweep_len(sweep_len),
    .sweep_ok(sweep_ok)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] r, input logic [31:0] d);
    regnum = r; wr_en = 1'b1; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; regnum = '0; wr_en = 1'b0; wr_data = '0; done = 1'b0;
    clear_mask = 1'b0; rs_addr = '0; rt_addr = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_mask", written_mask, 0);
    chk("rst_count", write_count, 0);
    chk("rst_pulse", sweep_done, 0);
    chk("rst_len", sweep_len, 0);

    // 1: write reg9, then async reset mid-cycle clears everything at once
    rs_addr = 5'd9;
    wr(5'd9, 32'hA5);
    chk("pre_rst_rd9", rs_data, 32'hA5);
    chk("pre_rst_cnt", write_count, 1);
    #2 reset = 1'b1;
    #1;
    chk("arst_rd9", rs_data, 0);
    chk("arst_mask", written_mask, 0);
    chk("arst_count", write_count, 0);
    tick();
    reset = 1'b0;

    // 2: up sweep 8..12
    for (int i = 0; i < 5; i++) wr(5'(8 + i), 32'h100 + 32'(i));
    done = 1'b1;
    tick();
    chk("up_pulse", sweep_done, 1);
    chk("up_len", sweep_len, 5);
    chk("up_ok", sweep_ok, 1);
    tick();
    chk("up_pulse_once", sweep_done, 0);
    chk("up_mask", written_mask, 32'h1F00);
    rs_addr = 5'd12; #1;
    chk("up_rd12", rs_data, 32'h104);
    chk("up_count", write_count, 5);

    // 3: down sweep including reg 0
    done = 1'b0;
    wr(5'd8, 32'h200);
    wr(5'd7, 32'h201);
    wr(5'd6, 32'h202);
    wr(5'd0, 32'h203);
    wr(5'd4, 32'h204);
    done = 1'b1;
    tick();
    chk("dn_pulse", sweep_done, 1);
    chk("dn_len", sweep_len, 4);
    chk("dn_ok", sweep_ok, 0);
    chk("dn_mask", written_mask, 32'h1FD0);
    rs_addr = 5'd0; rt_addr = 5'd8; #1;
    chk("dn_rd0", rs_data, 0);
    chk("dn_rd8", rt_data, 32'h200);
    chk("dn_count", write_count, 9);
    done = 1'b0;
    tick();

    // 4: no write bypass, both ports on the same register
    rs_addr = 5'd5; rt_addr = 5'd5;
    regnum = 5'd5; wr_en = 1'b1; wr_data = 32'h55; #1;
    chk("byp_old_rs", rs_data, 0);
    chk("byp_old_rt", rt_data, 0);
    tick();
    wr_en = 1'b0;
    chk("byp_new_rs", rs_data, 32'h55);
    chk("byp_new_rt", rt_data, 32'h55);

    // 5: clear_mask coincident with write; long done gives a single pulse
    clear_mask = 1'b1;
    wr(5'd3, 32'h33);
    clear_mask = 1'b0;
    chk("clr_mask", written_mask, 32'h8);
    chk("clr_count", write_count, 11);
    done = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (sweep_done) pulses++;
    end
    chk("held_pulses", 64'(pulses), 1);
    chk("held_len", sweep_len, 2);
    chk("held_ok", sweep_ok, 0);
    done = 1'b0;

    // 6: write count saturation
    for (int i = 0; i < 300; i++) wr(5'd1, 32'(i));
    rs_addr = 5'd1; #1;
    chk("sat_count", write_count, 255);
    chk("sat_rd1", rs_data, 299);
    chk("sat_mask", written_mask, 32'hA);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
